mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of address and data buses.
REQ-002 Parameter MEM_LATENCY, default 2: cycles from the main-memory issue edge to valid mem_rd; legal range 1..15.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Ports for the I-side (fetch refill) requester:
- i_req  input  1: request.
- i_addr  input  DATA_WIDTH: byte address.
- i_rdata  output  DATA_WIDTH: read word.
- i_ack  output  1: completion pulse.
REQ-006 Ports for the D-side (cache refill/writeback) requester:
- d_req  input  1: request.
- d_we  input  1: 1 = write.
- d_addr  input  DATA_WIDTH: byte address.
- d_wdata  input  DATA_WIDTH: write word.
- d_rdata  output  DATA_WIDTH: read word.
- d_ack  output  1: completion pulse.
REQ-007 Ports to main memory:
- mem_addr  output  DATA_WIDTH: word-aligned address.
- mem_wd  output  DATA_WIDTH: write data.
- mem_we  output  1: write enable.
- mem_re  output  1: read enable.
- mem_rd  input  DATA_WIDTH: read data.
REQ-008 Ports stall_f  output  1 and stall_m  output  1: stall requests to the fetch and memory pipeline stages.

Function
REQ-009 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE SHALL sample i_req/d_req, and on any request SHALL latch owner, word-aligned address {addr[31:2],2'b00}, wdata and we (we=0 for I-side), then enter ISSUE; with no request it SHALL remain in IDLE.
REQ-011 When exactly one request is high in IDLE, that requester SHALL be granted.
REQ-012 When both requests are high in IDLE, the requester other than last_grant SHALL be granted (round-robin).
REQ-013 ISSUE SHALL last one cycle and drive mem_re=~we and mem_we=we, with mem_addr/mem_wd set to the latched values.
REQ-014 ISSUE SHALL load cnt=MEM_LATENCY-1; if cnt=0 it SHALL go to RESP, else to WAIT.
REQ-015 WAIT SHALL decrement cnt each cycle and go to RESP in the cycle cnt reaches 0, giving exactly MEM_LATENCY-1 WAIT cycles.
REQ-016 RESP SHALL last one cycle: pulse the owner's ack high, capture mem_rd into the owner's rdata register (reads only; writes leave rdata unchanged), set last_grant=owner, and return to IDLE.
REQ-017 Latency SHALL be: request sampled in IDLE at cycle t -> ack high in cycle t+1+MEM_LATENCY.
REQ-018 mem_re and mem_we SHALL be 0 in every state other than ISSUE; mem_addr/mem_wd SHALL hold their last latched values.
REQ-019 Requests arriving while the FSM is not in IDLE SHALL be ignored until IDLE; the losing requester SHALL remain pending and be granted next.
REQ-020 Requesters SHALL hold req/addr/wdata/we stable until ack and drop req on the ack edge; re-asserting req in the following cycle SHALL be permitted, giving back-to-back service via IDLE.
REQ-021 stall_f SHALL equal i_req & ~i_ack, and stall_m SHALL equal d_req & ~d_ack (combinational).
REQ-022 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-023 On reset the block SHALL set: state=IDLE, cnt=0, last_grant=I (so D wins the first tie), i_rdata=d_rdata=0, i_ack=d_ack=0, mem_addr=mem_wd=0, mem_re=mem_we=0.
REQ-024 Reset asserted mid-operation SHALL abandon the in-flight access with no ack, and mem_re/mem_we SHALL be 0 from the following cycle.
REQ-025 Reset SHALL take precedence over every other event in the same cycle.

Structure
REQ-026 Package mem_arb_pkg SHALL hold typedef arb_state_t (IDLE/ISSUE/WAIT/RESP), typedef arb_owner_t (OWN_I/OWN_D) and constant CNT_W=4.
REQ-027 One combinational sub-module, rr_pick2, SHALL compute the grant from (i_req, d_req, last_grant); the FSM, counter and registers SHALL stay in mem_port_arbiter.

Verification (MEM_LATENCY=2)
REQ-028 Reset for 2 cycles, then idle -> all outputs 0, mem_re/mem_we never high.
REQ-029 i_req=1, i_addr=0x103, mem_rd=0xDEADBEEF -> mem_re high one cycle with mem_addr=0x100; i_ack at t+3 with i_rdata=0xDEADBEEF; stall_f high t..t+2.
REQ-030 i_req and d_req high simultaneously after reset -> D served first (d_ack at t+3), I issued next (i_ack at t+7); stall_f high throughout.
REQ-031 d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_we high exactly one cycle with those values; d_ack pulses; d_rdata unchanged.
REQ-032 Reset asserted during WAIT -> no ack, state IDLE, outputs at reset values; a new i_req is then serviced normally.
REQ-033 Both requesters continuously re-requesting for 8 transactions -> strict I/D alternation, never two acks in the same cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory-port arbiter.
// FSM states, requester identity and counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and stall wires
// shared between the arbiter (slave) and its users (master).
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_req;
  logic [DATA_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_ack;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rd;

  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rd,
    output i_rdata, i_ack,
    output d_rdata, d_ack,
    output mem_addr, mem_wd, mem_we, mem_re,
    output stall_f, stall_m
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rd,
    input  i_rdata, i_ack,
    input  d_rdata, d_ack,
    input  mem_addr, mem_wd, mem_we, mem_re,
    input  stall_f, stall_m
  );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin grant selection.
// A tie goes to the requester that was not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output logic       grant_vld,
  output arb_owner_t grant
);

  // pick the winner among the active requests
  always_comb begin
    grant_vld = i_req | d_req;
    grant     = OWN_I;
    if (i_req && d_req) begin
      grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port
// between the fetch (I) and data (D) refill requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MEM_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] ALIGN =
    ~DATA_WIDTH'(3);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  arb_owner_t last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic       grant_vld;
  arb_owner_t grant;
  logic       in_issue;
  logic       in_resp;

  rr_pick2 u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_q),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  // next-state, latch and capture decisions
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant;
          state_d = ISSUE;
          if (grant == OWN_D) begin
            addr_d  = bus.d_addr & ALIGN;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
          end else begin
            addr_d = bus.i_addr & ALIGN;
            we_d   = 1'b0;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = (CNT_LOAD == '0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!we_q) begin
          if (owner_q == OWN_D) begin
            d_rdata_d = bus.mem_rd;
          end else begin
            i_rdata_d = bus.mem_rd;
          end
        end
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, reset first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // strobes are masked by reset so an abandoned
  // access never acks or touches memory
  assign in_issue = (state_q == ISSUE) && !reset;
  assign in_resp  = (state_q == RESP) && !reset;

  assign bus.mem_re   = in_issue && !we_q;
  assign bus.mem_we   = in_issue && we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wdata_q;

  assign bus.i_ack = in_resp && (owner_q == OWN_I);
  assign bus.d_ack = in_resp && (owner_q == OWN_D);

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign bus.stall_f = bus.i_req && !bus.i_ack;
  assign bus.stall_m = bus.d_req && !bus.d_ack;

endmodule
